rs232_rx_fifo_pacer: RTL

Byte buffer placed between the RS232 receiver and transmitter in the loopback path. It captures every `rx_data`/`out_flag` strobe from the receiver into a FIFO. It re-issues the bytes to the transmitter's `data`/`flag` inputs, spaced at least one full frame time apart, so a byte never reaches the transmitter while it is still shifting the previous one.

---
 rtl/rs232_rx_fifo_pacer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rs232_rx_fifo_pacer.sv
// rs232_rx_fifo_pacer
// Buffers bytes strobed out of the RS232 receiver and re-issues them to the
// transmitter no faster than one frame time (FRAME_BITS*MAX_CNT clocks) apart.
// Optional feature: define RS232_FIFO_OVF_EN to build the sticky overflow flag;
// without it, overflow is tied low and dropped bytes are silently discarded.
module rs232_rx_fifo_pacer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int MAX_CNT    = 5208,
  parameter int FRAME_BITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_flag,
  output logic [7:0]        out_data,
  output logic              out_flag,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned GAP = 32'(FRAME_BITS) * 32'(MAX_CNT);
  localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  // WAIT leaves when the counter steps onto GAP-2, i.e. while it still reads GAP-3
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 32'd3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W:0]     r_wrPtr;
  logic [ADDR_W:0]     r_rdPtr;
  logic [CNT_W-1:0]    r_gapCnt;
  logic [ADDR_W:0]     r_count;
  logic                r_empty;
  logic                r_full;
  logic [7:0]          r_outData;
  logic                r_outFlag;
  logic [ADDR_W:0]     w_ptrCount;
  logic                w_ptrEmpty;
  logic                w_ptrFull;
  logic                w_pop;
  logic                w_push;

  // Occupancy straight from the pointers; drives push/pop decisions this cycle
  assign w_ptrCount = r_wrPtr - r_rdPtr;
  assign w_ptrEmpty = (w_ptrCount == '0);
  assign w_ptrFull  = (w_ptrCount == DEPTH_V);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_push     = in_flag && (!w_ptrFull || w_pop);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state and pop decision; the FSM only sees the registered empty flag
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) w_nextState = S_ISSUE;
      end
      S_ISSUE: begin
        w_pop       = !w_ptrEmpty;
        w_nextState = S_WAIT;
      end
      S_WAIT: begin
        if (r_gapCnt == GAP_LAST) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Write and read pointers, wrapping naturally at 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wrPtr[ADDR_W-1:0]] <= in_data;
  end

  // Registered status outputs, one cycle behind the pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_ptrCount;
      r_empty <= w_ptrEmpty;
      r_full  <= w_ptrFull;
    end
  end

  // Frame-gap counter: cleared on issue, counts through WAIT
  always_ff @(posedge clk) begin
    if (rst)                    r_gapCnt <= '0;
    else if (r_state == S_ISSUE) r_gapCnt <= '0;
    else if (r_state == S_WAIT)  r_gapCnt <= r_gapCnt + CNT_W'(1);
  end

  // Byte and one-cycle strobe toward the transmitter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outData <= 8'h00;
      r_outFlag <= 1'b0;
    end else begin
      r_outFlag <= (r_state == S_ISSUE);
      if (r_state == S_ISSUE) r_outData <= r_mem[r_rdPtr[ADDR_W-1:0]];
    end
  end

`ifdef RS232_FIFO_OVF_EN
  logic r_overflow;
  logic w_drop;

  assign w_drop = in_flag && w_ptrFull && !w_pop;

  // Sticky drop indicator, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)         r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  assign out_data = r_outData;
  assign out_flag = r_outFlag;
  assign count    = r_count;
  assign empty    = r_empty;
  assign full     = r_full;

endmodule
